// File: rtl/gray_step_monitor.sv
// Gray code step monitor: decodes the upstream Gray bus, checks single steps, counts wraps.
// Define GRAY_STEP_MON_BIDIR_EN to also accept down steps and expose DirDown.
module gray_step_monitor #(
    parameter int W     = 3,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [W-1:0]     GrayIn,
    input  logic             OvfIn,
    input  logic             Clear,
    output logic [W-1:0]     BinOut,
    output logic             Valid,
    output logic             StepPulse,
    output logic             WrapPulse,
    output logic [CNT_W-1:0] WrapCnt,
    output logic             OvfSeen,
`ifdef GRAY_STEP_MON_BIDIR_EN
    output logic             StepErr,
    output logic             DirDown
`else
    output logic             StepErr
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        ERR
    } state_t;

    state_t         state;
    logic [W-1:0]   prev_bin;
    logic           ovf_d;
    logic [W-1:0]   dec;
    logic [W-1:0]   up;
    logic [W-1:0]   dn;

    // Binary bit i is the XOR of all Gray bits from i upward
    always_comb begin
        dec = '0;
        for (int i = 0; i < W; i++) begin
            dec[i] = ^(GrayIn >> i);
        end
    end

    assign up = prev_bin + W'(1);
    assign dn = prev_bin - W'(1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            prev_bin  <= '0;
            ovf_d     <= 1'b0;
            BinOut    <= '0;
            Valid     <= 1'b0;
            StepPulse <= 1'b0;
            WrapPulse <= 1'b0;
            WrapCnt   <= '0;
            OvfSeen   <= 1'b0;
            StepErr   <= 1'b0;
`ifdef GRAY_STEP_MON_BIDIR_EN
            DirDown   <= 1'b0;
`endif
        end else begin
            BinOut    <= dec;
            prev_bin  <= dec;
            ovf_d     <= OvfIn;
            StepPulse <= 1'b0;
            WrapPulse <= 1'b0;

            if (Clear)
                OvfSeen <= 1'b0;
            else if (OvfIn && !ovf_d)
                OvfSeen <= 1'b1;

            if (Clear) begin
                state   <= IDLE;
                Valid   <= 1'b0;
                StepErr <= 1'b0;
                WrapCnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        Valid <= 1'b1;
                        state <= TRACK;
                    end
                    TRACK: begin
                        if (dec == up) begin
                            StepPulse <= 1'b1;
`ifdef GRAY_STEP_MON_BIDIR_EN
                            DirDown   <= 1'b0;
`endif
                            if (prev_bin == '1) begin
                                WrapPulse <= 1'b1;
                                WrapCnt   <= WrapCnt + CNT_W'(1);
                            end
`ifdef GRAY_STEP_MON_BIDIR_EN
                        end else if (dec == dn) begin
                            StepPulse <= 1'b1;
                            DirDown   <= 1'b1;
                            if (prev_bin == '0) begin
                                WrapPulse <= 1'b1;
                                WrapCnt   <= WrapCnt - CNT_W'(1);
                            end
`endif
                        end else if (dec != prev_bin) begin
                            StepErr <= 1'b1;
                            state   <= ERR;
                        end
                    end
                    ERR: begin
                        StepErr <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifndef GRAY_STEP_MON_BIDIR_EN
    logic unused_dn;
    assign unused_dn = ^dn;
`endif

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed bench for gray_step_monitor with a cycle-level reference model.
// Builds with or without GRAY_STEP_MON_BIDIR_EN.
module tb_gray_step_monitor;
    localparam int W     = 3;
    localparam int CNT_W = 8;
    localparam int N     = 1 << W;
    localparam int M     = 1 << CNT_W;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [W-1:0]     GrayIn = '0;
    logic             OvfIn = 1'b0;
    logic             Clear = 1'b0;
    logic [W-1:0]     BinOut;
    logic             Valid;
    logic             StepPulse;
    logic             WrapPulse;
    logic [CNT_W-1:0] WrapCnt;
    logic             OvfSeen;
    logic             StepErr;
`ifdef GRAY_STEP_MON_BIDIR_EN
    logic             DirDown;
`endif

    gray_step_monitor #(.W(W), .CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .GrayIn    (GrayIn),
        .OvfIn     (OvfIn),
        .Clear     (Clear),
        .BinOut    (BinOut),
        .Valid     (Valid),
        .StepPulse (StepPulse),
        .WrapPulse (WrapPulse),
        .WrapCnt   (WrapCnt),
        .OvfSeen   (OvfSeen),
`ifdef GRAY_STEP_MON_BIDIR_EN
        .StepErr   (StepErr),
        .DirDown   (DirDown)
`else
        .StepErr   (StepErr)
`endif
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model state: mode 0 = waiting for first sample, 1 = tracking, 2 = error
    int m_mode = 0;
    int m_valid = 0;
    int m_bin = 0;
    int m_step = 0;
    int m_wrap = 0;
    int m_cnt = 0;
    int m_ovfseen = 0;
    int m_ovfd = 0;
    int m_err = 0;
    int m_dir = 0;

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int gdec(input int g);
        for (int b = 0; b < N; b++)
            if ((b ^ (b >> 1)) == g) return b;
        return -1;
    endfunction

    task automatic model_step(input bit rst, input bit clr, input int g, input bit ovf);
        int d;
        if (rst) begin
            m_mode = 0; m_valid = 0; m_bin = 0; m_step = 0; m_wrap = 0;
            m_cnt = 0; m_ovfseen = 0; m_ovfd = 0; m_err = 0; m_dir = 0;
            return;
        end
        d = gdec(g);
        m_step = 0;
        m_wrap = 0;
        if (clr) begin
            m_mode = 0; m_valid = 0; m_err = 0; m_cnt = 0; m_ovfseen = 0;
        end else begin
            if (ovf && m_ovfd == 0) m_ovfseen = 1;
            if (m_mode == 0) begin
                m_valid = 1;
                m_mode = 1;
            end else if (m_mode == 1 && d != m_bin) begin
                if (d == (m_bin + 1) % N) begin
                    m_step = 1;
                    m_dir = 0;
                    if (m_bin == N - 1) begin
                        m_wrap = 1;
                        m_cnt = (m_cnt + 1) % M;
                    end
`ifdef GRAY_STEP_MON_BIDIR_EN
                end else if (d == (m_bin + N - 1) % N) begin
                    m_step = 1;
                    m_dir = 1;
                    if (m_bin == 0) begin
                        m_wrap = 1;
                        m_cnt = (m_cnt + M - 1) % M;
                    end
`endif
                end else begin
                    m_err = 1;
                    m_mode = 2;
                end
            end
        end
        m_bin = d;
        m_ovfd = ovf;
    endtask

    task automatic cyc(input bit rst, input bit clr, input int g, input bit ovf);
        Reset  = rst;
        Clear  = clr;
        GrayIn = g[W-1:0];
        OvfIn  = ovf;
        @(posedge Clk);
        model_step(rst, clr, g, ovf);
        chk_en = 1'b1;
        @(negedge Clk);
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            check("BinOut", int'(BinOut), m_bin);
            check("Valid", int'(Valid), m_valid);
            check("StepPulse", int'(StepPulse), m_step);
            check("WrapPulse", int'(WrapPulse), m_wrap);
            check("WrapCnt", int'(WrapCnt), m_cnt);
            check("OvfSeen", int'(OvfSeen), m_ovfseen);
            check("StepErr", int'(StepErr), m_err);
`ifdef GRAY_STEP_MON_BIDIR_EN
            check("DirDown", int'(DirDown), m_dir);
`endif
        end
    end

    int seq [8] = '{1, 3, 2, 6, 7, 5, 4, 0};
    int steps;
    int wraps;

    initial begin
        // 1: reset then hold 000
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("rst_valid", int'(Valid), 0);
        check("rst_wrapcnt", int'(WrapCnt), 0);
        check("rst_binout", int'(BinOut), 0);
        cyc(0, 0, 0, 0);
        check("t1_valid", int'(Valid), 1);
        check("t1_model_valid", m_valid, 1);
        repeat (4) cyc(0, 0, 0, 0);
        check("t1_steperr", int'(StepErr), 0);
        check("t1_step", int'(StepPulse), 0);

        // 2: full Gray cycle
        steps = 0;
        wraps = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, seq[i], 0);
            check("t2_bin", int'(BinOut), (i + 1) % 8);
            steps += int'(StepPulse);
            wraps += int'(WrapPulse);
        end
        check("t2_last_wrap", int'(WrapPulse), 1);
        check("t2_steps", steps, 8);
        check("t2_wraps", wraps, 1);
        check("t2_wrapcnt", int'(WrapCnt), 1);
        check("t2_model_cnt", m_cnt, 1);
        check("t2_steperr", int'(StepErr), 0);

        // 3: illegal 1 -> 3, then Clear
        cyc(0, 0, 1, 0);
        check("t3_bin1", int'(BinOut), 1);
        cyc(0, 0, 2, 0);
        check("t3_err", int'(StepErr), 1);
        check("t3_bin3", int'(BinOut), 3);
        check("t3_cnt", int'(WrapCnt), 1);
        check("t3_nopulse", int'(StepPulse), 0);
        cyc(0, 0, 3, 0);
        check("t3_err_hold", int'(StepErr), 1);
        check("t3_bin_track", int'(BinOut), 2);
        check("t3_no_step_in_err", int'(StepPulse), 0);
        cyc(0, 1, 3, 0);
        check("t3_clr_err", int'(StepErr), 0);
        check("t3_clr_cnt", int'(WrapCnt), 0);
        check("t3_clr_valid", int'(Valid), 0);
        cyc(0, 0, 3, 0);
        check("t3_valid_back", int'(Valid), 1);

        // 4: overflow edge detection
        cyc(0, 0, 3, 1);
        check("t4_ovf_edge", int'(OvfSeen), 1);
        repeat (3) cyc(0, 0, 3, 1);
        check("t4_ovf_held", int'(OvfSeen), 1);
        cyc(0, 0, 3, 0);
        check("t4_ovf_sticky", int'(OvfSeen), 1);
        cyc(0, 1, 3, 1);
        check("t4_clear_wins", int'(OvfSeen), 0);
        cyc(0, 0, 3, 1);
        check("t4_no_new_edge", int'(OvfSeen), 0);
        check("t4_model_ovf", m_ovfseen, 0);

        // 5: error, then Reset together with Clear
        cyc(0, 0, 0, 0);
        check("t5_err", int'(StepErr), 1);
        cyc(1, 1, 5, 1);
        check("t5_bin", int'(BinOut), 0);
        check("t5_valid", int'(Valid), 0);
        check("t5_err0", int'(StepErr), 0);
        check("t5_cnt", int'(WrapCnt), 0);
        check("t5_ovf", int'(OvfSeen), 0);

        // 6: 0 -> 7 down step
        cyc(0, 0, 0, 0);
        cyc(0, 0, 4, 0);
`ifdef GRAY_STEP_MON_BIDIR_EN
        check("t6_step", int'(StepPulse), 1);
        check("t6_wrap", int'(WrapPulse), 1);
        check("t6_dir", int'(DirDown), 1);
        check("t6_cnt", int'(WrapCnt), 255);
        check("t6_err", int'(StepErr), 0);
`else
        check("t6_err", int'(StepErr), 1);
        check("t6_step", int'(StepPulse), 0);
        check("t6_cnt", int'(WrapCnt), 0);
`endif

        // upstream overflow jump 7 -> 0 with OvfIn is a legal wrap
        cyc(1, 0, 0, 0);
        cyc(0, 0, 4, 0);
        cyc(0, 0, 0, 1);
        check("ovj_wrap", int'(WrapPulse), 1);
        check("ovj_cnt", int'(WrapCnt), 1);
        check("ovj_ovf", int'(OvfSeen), 1);
        check("ovj_err", int'(StepErr), 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
